// File: rtl/ball_motion_if.sv
// Bundle between the ball motion engine and its drivers/consumers: frame and
// charge pulses, collision and re-spot inputs, plus position, shot and status outputs.
interface ball_motion_if #(
  parameter int POS_W   = 11,
  parameter int SPEED_W = 16
) ();
  logic                      startOfFrame;
  logic                      chargeUp;
  logic                      chargeDown;
  logic                      chargeLeft;
  logic                      chargeRight;
  logic                      releaseBall;
  logic                      collision;
  logic [3:0]                HitEdgeCode;
  logic                      placeValid;
  logic signed [POS_W-1:0]   placeX;
  logic signed [POS_W-1:0]   placeY;
  logic signed [POS_W-1:0]   topLeftX;
  logic signed [POS_W-1:0]   topLeftY;
  logic signed [SPEED_W-1:0] shotX;
  logic signed [SPEED_W-1:0] shotY;
  logic                      moving;
  logic                      shotDone;
  logic [0:0]                state_dbg;
  logic signed [SPEED_W-1:0] speed_x_dbg;
  logic signed [SPEED_W-1:0] speed_y_dbg;

  // All inputs are single-cycle qualifiers sampled on the rising clock edge;
  // there is no back-pressure, so every pulse is consumed in the cycle it is high.
  modport master (
    output startOfFrame, chargeUp, chargeDown, chargeLeft, chargeRight,
           releaseBall, collision, HitEdgeCode, placeValid, placeX, placeY,
    input  topLeftX, topLeftY, shotX, shotY, moving, shotDone,
           state_dbg, speed_x_dbg, speed_y_dbg
  );

  modport slave (
    input  startOfFrame, chargeUp, chargeDown, chargeLeft, chargeRight,
           releaseBall, collision, HitEdgeCode, placeValid, placeX, placeY,
    output topLeftX, topLeftY, shotX, shotY, moving, shotDone,
           state_dbg, speed_x_dbg, speed_y_dbg
  );
endinterface

// File: rtl/ball_motion_engine.sv
// Single-ball trajectory engine: shot charging, release, per-frame friction and
// edge-coded bounce. Define BALL_BOUNCE_DAMP_EN to make each bounce lose |v|>>2.
module ball_motion_engine #(
  parameter int POS_W          = 11,
  parameter int FRAC_BITS      = 6,
  parameter int SPEED_W        = 16,
  parameter int INITIAL_X      = 100,
  parameter int INITIAL_Y      = 220,
  parameter int SPEED_STEP     = 200,
  parameter int MAX_SHOT_SPEED = 1000,
  parameter int FRICTION_SHIFT = 5,
  parameter int MIN_SPEED      = 2
) (
  input  logic         clk,
  input  logic         reset,
  ball_motion_if.slave bus
);

  localparam int ACC_W = POS_W + FRAC_BITS;
  localparam int SUM_W = ACC_W + SPEED_W + 1;
  localparam int SW2   = SPEED_W + 2;

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_ROLLING = 1'b1;

  localparam logic signed [ACC_W-1:0] ACC_MAX    = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN    = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] INIT_X_ACC = ACC_W'(INITIAL_X * (2 ** FRAC_BITS));
  localparam logic signed [ACC_W-1:0] INIT_Y_ACC = ACC_W'(INITIAL_Y * (2 ** FRAC_BITS));
  localparam logic signed [SW2-1:0]   SHOT_MAX   = SW2'(MAX_SHOT_SPEED);
  localparam logic signed [SW2-1:0]   SHOT_MIN   = -SW2'(MAX_SHOT_SPEED);
  localparam logic signed [SW2-1:0]   STEP       = SW2'(SPEED_STEP);
  localparam logic signed [SW2-1:0]   MIN_MAG    = SW2'(MIN_SPEED);

  logic [0:0]                state_q, state_d;
  logic signed [ACC_W-1:0]   pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic signed [SPEED_W-1:0] spd_x_q, spd_x_d, spd_y_q, spd_y_d;
  logic signed [SPEED_W-1:0] shot_x_q, shot_x_d, shot_y_q, shot_y_d;
  logic                      lock_x_q, lock_x_d, lock_y_q, lock_y_d;
  logic                      shot_done_q, shot_done_d;

  logic                      refl_x, refl_y;
  logic signed [SPEED_W-1:0] spd_x_ref, spd_y_ref, fric_x, fric_y;

  function automatic logic signed [ACC_W-1:0] acc_add(
    input logic signed [ACC_W-1:0]   p,
    input logic signed [SPEED_W-1:0] v
  );
    logic signed [SUM_W-1:0] s;
    s = SUM_W'(p) + SUM_W'(v);
    if (s > SUM_W'(ACC_MAX))      return ACC_MAX;
    else if (s < SUM_W'(ACC_MIN)) return ACC_MIN;
    else                          return ACC_W'(s);
  endfunction

  function automatic logic signed [SPEED_W-1:0] shot_step(
    input logic signed [SPEED_W-1:0] shot,
    input logic                      inc,
    input logic                      dec
  );
    logic signed [SW2-1:0] s;
    s = SW2'(shot);
    if (inc) s = s + STEP;
    if (dec) s = s - STEP;
    if (s > SHOT_MAX)      s = SHOT_MAX;
    else if (s < SHOT_MIN) s = SHOT_MIN;
    return SPEED_W'(s);
  endfunction

  // Proportional drag; a speed that would cross zero or end up tiny is snapped to rest.
  function automatic logic signed [SPEED_W-1:0] apply_friction(
    input logic signed [SPEED_W-1:0] v
  );
    logic signed [SW2-1:0] ve, mag, dec, vn, vn_mag;
    ve     = SW2'(v);
    mag    = ve[SW2-1] ? -ve : ve;
    dec    = SW2'(1) + (mag >>> FRICTION_SHIFT);
    vn     = ve[SW2-1] ? (ve + dec) : (ve - dec);
    vn_mag = vn[SW2-1] ? -vn : vn;
    if (ve == '0 || vn_mag <= MIN_MAG || vn[SW2-1] != ve[SW2-1]) return '0;
    return SPEED_W'(vn);
  endfunction

  function automatic logic signed [SPEED_W-1:0] reflect_speed(
    input logic signed [SPEED_W-1:0] v
  );
`ifdef BALL_BOUNCE_DAMP_EN
    logic signed [SW2-1:0] ve, mag;
    ve  = SW2'(v);
    mag = ve[SW2-1] ? -ve : ve;
    ve  = ve[SW2-1] ? (ve + (mag >>> 2)) : (ve - (mag >>> 2));
    return SPEED_W'(-ve);
`else
    return -v;
`endif
  endfunction

  always_comb begin
    state_d     = state_q;
    pos_x_d     = pos_x_q;
    pos_y_d     = pos_y_q;
    spd_x_d     = spd_x_q;
    spd_y_d     = spd_y_q;
    shot_x_d    = shot_x_q;
    shot_y_d    = shot_y_q;
    shot_done_d = 1'b0;
    lock_x_d    = bus.startOfFrame ? 1'b0 : lock_x_q;
    lock_y_d    = bus.startOfFrame ? 1'b0 : lock_y_q;

    // A bounce only counts when the ball is heading into the edge it touches.
    refl_x = (state_q == ST_ROLLING) && bus.collision && !lock_x_q &&
             ((bus.HitEdgeCode[3] && spd_x_q[SPEED_W-1]) ||
              (bus.HitEdgeCode[1] && !spd_x_q[SPEED_W-1] && spd_x_q != '0));
    refl_y = (state_q == ST_ROLLING) && bus.collision && !lock_y_q &&
             ((bus.HitEdgeCode[2] && spd_y_q[SPEED_W-1]) ||
              (bus.HitEdgeCode[0] && !spd_y_q[SPEED_W-1] && spd_y_q != '0));
    spd_x_ref = refl_x ? reflect_speed(spd_x_q) : spd_x_q;
    spd_y_ref = refl_y ? reflect_speed(spd_y_q) : spd_y_q;
    fric_x    = apply_friction(spd_x_ref);
    fric_y    = apply_friction(spd_y_ref);

    if (bus.placeValid) begin
      state_d  = ST_IDLE;
      pos_x_d  = {bus.placeX, {FRAC_BITS{1'b0}}};
      pos_y_d  = {bus.placeY, {FRAC_BITS{1'b0}}};
      spd_x_d  = '0;
      spd_y_d  = '0;
      shot_x_d = '0;
      shot_y_d = '0;
      lock_x_d = 1'b0;
      lock_y_d = 1'b0;
    end else if (state_q == ST_IDLE) begin
      if (bus.releaseBall && (shot_x_q != '0 || shot_y_q != '0)) begin
        state_d  = ST_ROLLING;
        spd_x_d  = shot_x_q;
        spd_y_d  = shot_y_q;
        shot_x_d = '0;
        shot_y_d = '0;
      end else begin
        shot_x_d = shot_step(shot_x_q, bus.chargeRight, bus.chargeLeft);
        shot_y_d = shot_step(shot_y_q, bus.chargeDown, bus.chargeUp);
      end
    end else begin
      spd_x_d  = spd_x_ref;
      spd_y_d  = spd_y_ref;
      lock_x_d = lock_x_d | refl_x;
      lock_y_d = lock_y_d | refl_y;
      // Position moves with the speed held before any same-cycle bounce.
      if (bus.startOfFrame) begin
        pos_x_d = acc_add(pos_x_q, spd_x_q);
        pos_y_d = acc_add(pos_y_q, spd_y_q);
        spd_x_d = fric_x;
        spd_y_d = fric_y;
        if (fric_x == '0 && fric_y == '0) begin
          state_d     = ST_IDLE;
          shot_done_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      pos_x_q     <= INIT_X_ACC;
      pos_y_q     <= INIT_Y_ACC;
      spd_x_q     <= '0;
      spd_y_q     <= '0;
      shot_x_q    <= '0;
      shot_y_q    <= '0;
      lock_x_q    <= 1'b0;
      lock_y_q    <= 1'b0;
      shot_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
      spd_x_q     <= spd_x_d;
      spd_y_q     <= spd_y_d;
      shot_x_q    <= shot_x_d;
      shot_y_q    <= shot_y_d;
      lock_x_q    <= lock_x_d;
      lock_y_q    <= lock_y_d;
      shot_done_q <= shot_done_d;
    end
  end

  assign bus.topLeftX    = pos_x_q[ACC_W-1:FRAC_BITS];
  assign bus.topLeftY    = pos_y_q[ACC_W-1:FRAC_BITS];
  assign bus.shotX       = shot_x_q;
  assign bus.shotY       = shot_y_q;
  assign bus.moving      = (state_q == ST_ROLLING);
  assign bus.shotDone    = shot_done_q;
  assign bus.state_dbg   = state_q;
  assign bus.speed_x_dbg = spd_x_q;
  assign bus.speed_y_dbg = spd_y_q;

endmodule

// File: tb/tb_ball_motion_engine.sv
// Directed bench for ball_motion_engine with hand-computed positions and speeds.
module tb_ball_motion_engine;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  ball_motion_if #(.POS_W(11), .SPEED_W(16)) bus ();

  ball_motion_engine dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    if (obs != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.startOfFrame = 1'b0;
    bus.chargeUp     = 1'b0;
    bus.chargeDown   = 1'b0;
    bus.chargeLeft   = 1'b0;
    bus.chargeRight  = 1'b0;
    bus.releaseBall  = 1'b0;
    bus.collision    = 1'b0;
    bus.HitEdgeCode  = 4'b0000;
    bus.placeValid   = 1'b0;
    bus.placeX       = '0;
    bus.placeY       = '0;
  endtask

  task automatic charge(input logic r, input logic l, input logic d, input logic u);
    bus.chargeRight = r;
    bus.chargeLeft  = l;
    bus.chargeDown  = d;
    bus.chargeUp    = u;
    tick();
    clear_inputs();
  endtask

  task automatic frame();
    bus.startOfFrame = 1'b1;
    tick();
    clear_inputs();
  endtask

  task automatic release_ball();
    bus.releaseBall = 1'b1;
    tick();
    clear_inputs();
  endtask

  task automatic place(input int x, input int y);
    bus.placeValid = 1'b1;
    bus.placeX     = 11'(x);
    bus.placeY     = 11'(y);
    tick();
    clear_inputs();
  endtask

  task automatic hit(input logic [3:0] code, input int cycles, input logic with_frame);
    bus.collision    = 1'b1;
    bus.HitEdgeCode  = code;
    bus.startOfFrame = with_frame;
    for (int i = 0; i < cycles; i++) begin
      tick();
      bus.startOfFrame = 1'b0;
    end
    clear_inputs();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    clear_inputs();
    tick();
    tick();
    check("rst_x", bus.topLeftX, 100);
    check("rst_y", bus.topLeftY, 220);
    check("rst_moving", int'(bus.moving), 0);
    check("rst_shot_done", int'(bus.shotDone), 0);
    reset = 1'b0;
    tick();
    repeat (3) frame();
    check("idle_x", bus.topLeftX, 100);
    check("idle_y", bus.topLeftY, 220);
    check("idle_moving", int'(bus.moving), 0);
    check("idle_shot_x", bus.shotX, 0);
    check("idle_shot_y", bus.shotY, 0);

    // Two right charges then release: 400 per frame in 1/64 px.
    charge(1'b1, 1'b0, 1'b0, 1'b0);
    charge(1'b1, 1'b0, 1'b0, 1'b0);
    check("charge_shot_x", bus.shotX, 400);
    release_ball();
    check("rel_moving", int'(bus.moving), 1);
    check("rel_shot_x", bus.shotX, 0);
    check("rel_speed_x", bus.speed_x_dbg, 400);
    frame();
    check("f1_x", bus.topLeftX, 106);
    check("f1_y", bus.topLeftY, 220);
    check("f1_speed_x", bus.speed_x_dbg, 387);
    check("f1_moving", int'(bus.moving), 1);
    frame();
    check("f2_x", bus.topLeftX, 112);
    check("f2_speed_x", bus.speed_x_dbg, 374);

    place(50, 60);
    check("place_x", bus.topLeftX, 50);
    check("place_y", bus.topLeftY, 60);
    check("place_moving", int'(bus.moving), 0);
    check("place_speed_x", bus.speed_x_dbg, 0);
    check("place_done0", int'(bus.shotDone), 0);
    tick();
    check("place_done1", int'(bus.shotDone), 0);

    for (int i = 0; i < 5; i++) charge(1'b0, 1'b0, 1'b1, 1'b0);
    check("shot_y_5", bus.shotY, 1000);
    charge(1'b0, 1'b0, 1'b1, 1'b0);
    charge(1'b0, 1'b0, 1'b1, 1'b0);
    check("shot_y_sat", bus.shotY, 1000);
    charge(1'b0, 1'b0, 1'b1, 1'b1);
    check("shot_y_cancel", bus.shotY, 1000);
    charge(1'b0, 1'b0, 1'b0, 1'b1);
    check("shot_y_up", bus.shotY, 800);
    charge(1'b1, 1'b1, 1'b0, 1'b0);
    check("shot_x_cancel", bus.shotX, 0);
    place(50, 60);
    check("place_clr_shot_y", bus.shotY, 0);

    // Bounce sequence starting from x accumulator 3200, vX=400.
    charge(1'b1, 1'b0, 1'b0, 1'b0);
    charge(1'b1, 1'b0, 1'b0, 1'b0);
    release_ball();
    hit(4'b0010, 3, 1'b0);
    check("refl_once", bus.speed_x_dbg, -400);
    frame();
    check("refl_f_x", bus.topLeftX, 43);
    check("refl_f_speed", bus.speed_x_dbg, -387);
    hit(4'b0010, 1, 1'b0);
    check("refl_wrong_dir", bus.speed_x_dbg, -387);
    hit(4'b1000, 1, 1'b1);
    check("refl_sof_x", bus.topLeftX, 37);
    check("refl_sof_speed", bus.speed_x_dbg, 374);
    hit(4'b0010, 1, 1'b0);
    check("refl_locked", bus.speed_x_dbg, 374);
    frame();
    check("unlock_x", bus.topLeftX, 43);
    check("unlock_speed", bus.speed_x_dbg, 362);
    hit(4'b0010, 1, 1'b0);
    check("refl_after_frame", bus.speed_x_dbg, -362);

    // Decay a 200 shot down to 3, then one more frame stops the ball.
    place(50, 60);
    charge(1'b1, 1'b0, 1'b0, 1'b0);
    release_ball();
    for (int i = 0; i < 400; i++) begin
      if (bus.speed_x_dbg == 16'sd3) break;
      frame();
    end
    check("decay_speed3", bus.speed_x_dbg, 3);
    check("decay_moving", int'(bus.moving), 1);
    check("decay_done_pre", int'(bus.shotDone), 0);
    frame();
    check("stop_speed", bus.speed_x_dbg, 0);
    check("stop_moving", int'(bus.moving), 0);
    check("stop_state", int'(bus.state_dbg), 0);
    check("stop_done", int'(bus.shotDone), 1);
    check("stop_y", bus.topLeftY, 60);
    tick();
    check("stop_done_clr", int'(bus.shotDone), 0);
    release_ball();
    check("rel_zero_moving", int'(bus.moving), 0);
    check("rel_zero_speed", bus.speed_x_dbg, 0);

    // Negative positions floor toward minus infinity.
    place(0, 0);
    charge(1'b0, 1'b1, 1'b0, 1'b0);
    check("shot_x_neg", bus.shotX, -200);
    release_ball();
    frame();
    check("neg_floor_x", bus.topLeftX, -4);
    check("neg_speed", bus.speed_x_dbg, -193);

    // Asynchronous reset between clock edges.
    #2;
    reset = 1'b1;
    #1;
    check("arst_x", bus.topLeftX, 100);
    check("arst_y", bus.topLeftY, 220);
    check("arst_moving", int'(bus.moving), 0);
    check("arst_speed", bus.speed_x_dbg, 0);
    tick();
    reset = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ball_motion_engine.md
Name: ball_motion_engine

Overview:
- Parametrised successor to the single-ball motion block: one ball's trajectory in signed fixed point, with shot charging, release, per-frame friction, edge-coded bounce and external re-placement.
- Adds an explicit IDLE/ROLLING state machine, proportional friction, shot saturation, one bounce per axis per frame, a shot-done pulse and a place port for re-spotting after a pocket.
- Sits between keyboard decode / collision logic and the ball bitmap drawer.

Parameters:
POS_W, 11, integer pixel width of topLeftX/topLeftY (signed)
FRAC_BITS, 6, fractional bits of position accumulator (1/64 px)
SPEED_W, 16, signed width of speed and shot registers
INITIAL_X, 100, reset X pixel
INITIAL_Y, 220, reset Y pixel
SPEED_STEP, 200, shot increment per charge pulse
MAX_SHOT_SPEED, 1000, shot magnitude limit per axis
FRICTION_SHIFT, 5, proportional friction divisor exponent
MIN_SPEED, 2, speed magnitude at or below which axis stops

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
startOfFrame  in  1  one-cycle pulse per frame
chargeUp / chargeDown / chargeLeft / chargeRight  in  1 each  one-cycle charge pulses
releaseBall  in  1  fire stored shot
collision  in  1  ball overlaps an object this cycle
HitEdgeCode  in  4  [3]=left [2]=top [1]=right [0]=bottom
placeValid  in  1  re-spot request
placeX / placeY  in  POS_W each  re-spot pixel
topLeftX / topLeftY  out  POS_W each  signed pixel position
shotX / shotY  out  SPEED_W each  charged shot, for cue display
moving  out  1  high in ROLLING
shotDone  out  1  one-cycle pulse on ROLLING->IDLE

Behaviour:
- Reset (async, active-high): state IDLE, speeds 0, shots 0, position = INITIAL*2^FRAC_BITS, topLeftX=INITIAL_X, topLeftY=INITIAL_Y, moving=0, shotDone=0, bounce locks clear.
- Priority per cycle: reset > placeValid > all else.
- placeValid: position <= place*2^FRAC_BITS, speeds 0, shots 0, state IDLE, no shotDone; effect visible next cycle.
- IDLE:
  - chargeRight: shotX += SPEED_STEP; chargeLeft: shotX -= SPEED_STEP. Same for Down(+)/Up(-) on Y.
  - Result saturates to ±MAX_SHOT_SPEED. Opposing pulses in the same cycle cancel.
  - releaseBall with shotX or shotY nonzero: speeds <= shots, shots <= 0, state ROLLING. With both shots zero: ignored.
- ROLLING: charge and release ignored; shots held at 0.
- Collision (ROLLING only), per axis:
  - Reflect X if (left edge and vX<0) or (right edge and vX>0), and X lock clear; set X lock. Y likewise with top/bottom.
  - Locks clear on every startOfFrame.
  - Reflection negates the speed register.
- startOfFrame in ROLLING:
  - pos <= pos + v, using the pre-reflection register value.
  - Friction: v' = v − sign(v)*(1 + (|v| >> FRICTION_SHIFT)), where v is post-reflection if a reflection occurs this cycle. If |v'| <= MIN_SPEED or sign(v') != sign(v), then v' = 0.
  - If both v' are 0: state IDLE, shotDone=1 the next cycle.
- Position accumulator: POS_W+FRAC_BITS signed, saturating at its range limits.
- Outputs: topLeft = accumulator >>> FRAC_BITS (arithmetic, floor), registered, 0-cycle latency from the accumulator.
- moving is state==ROLLING.
- startOfFrame in IDLE: no position change.

Optional Feature:
- BALL_BOUNCE_DAMP_EN defined: a reflected speed also loses |v|>>2 before sign inversion, then friction applies normally.
- Undefined: reflection is lossless negation.

Test Plan:
- Reset then idle frames -> topLeftX=100, topLeftY=220, moving=0, shotX=shotY=0.
- 2x chargeRight, release, one startOfFrame -> speedX=400 loaded. After the frame: accumulator 6400+400=6800, topLeftX=106, speedX=400−13=387, moving=1.
- 7x chargeDown -> shotY saturates at 1000. Then chargeUp and chargeDown in the same cycle -> shotY stays 1000.
- Rolling with vX=300, collision with HitEdgeCode=0010 held 3 cycles -> single reflection to −300. Next frame vX=−300+10=−290; without a new frame, no further flip.
- Rolling ends (vX=3, vY=0 at frame) -> vX=0, state IDLE, shotDone high exactly one cycle. Release with zero shot -> no change.
- Mid-roll placeValid with placeX=50, placeY=60 -> topLeft=(50,60), speeds 0, moving=0, no shotDone. Async reset mid-roll -> (100,220) immediately.
